uart_tx_arb: RTL

- Two-requester arbiter that shares one UART transmitter byte port between a CPU register interface (rq0) and a debug/monitor source (rq1).
- Grants the transmitter per byte with round-robin fairness.
- A requester may hold the grant across a multi-byte frame via a lock signal; a watchdog counted in UART prescaler ticks breaks abandoned locks.
- Sits directly in front of the UART TX byte port and drives its byte/enable inputs from the granted requester.

---
 rtl/uart_tx_arb.sv | 133 +++++++++++++
 1 files changed

// File: rtl/uart_tx_arb.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arb
// Brief    : Round-robin arbiter sharing one UART TX byte port between two
//            requesters, with frame locking and a lock watchdog.
// Revision : 1.0
// ============================================================================
module uart_tx_arb #(
    parameter int TMO_W    = 12,
    parameter int LOCK_TMO = 4095
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_cken_i,
    input  logic [7:0] rq0_byte_i,
    input  logic       rq0_valid_i,
    input  logic       rq0_lock_i,
    output logic       rq0_ready_o,
    input  logic [7:0] rq1_byte_i,
    input  logic       rq1_valid_i,
    input  logic       rq1_lock_i,
    output logic       rq1_ready_o,
    output logic [7:0] txu_byte_o,
    output logic       txu_en_o,
    input  logic       txu_ready_i,
    output logic [1:0] grant_o,
    output logic       tmo_o
);

    localparam logic [TMO_W-1:0] c_lock_tmo = TMO_W'(LOCK_TMO);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last;
    logic             w_last_nxt;
    logic [TMO_W-1:0] r_cnt;
    logic [TMO_W-1:0] w_cnt_nxt;
    logic [TMO_W-1:0] w_cnt_inc;
    logic             r_tmo;
    logic             w_tmo_nxt;

    // Owner-relative view of the requester currently holding the grant
    logic       w_own;
    logic       w_valid;
    logic       w_lock;
    logic [7:0] w_byte;
    logic       w_xfer;

    assign w_own     = (r_state == ST_GNT1);
    assign w_valid   = w_own ? rq1_valid_i : rq0_valid_i;
    assign w_lock    = w_own ? rq1_lock_i  : rq0_lock_i;
    assign w_byte    = w_own ? rq1_byte_i  : rq0_byte_i;
    assign w_xfer    = (r_state != ST_IDLE) && w_valid && txu_ready_i;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign tmo_o     = r_tmo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
            r_cnt   <= '0;
            r_tmo   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_last  <= w_last_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tmo   <= w_tmo_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_cnt_nxt   = r_cnt;
        w_tmo_nxt   = 1'b0;
        grant_o     = 2'b00;
        txu_byte_o  = 8'h00;
        txu_en_o    = 1'b0;
        rq0_ready_o = 1'b0;
        rq1_ready_o = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                // Clearing here covers the "cleared on grant entry" rule
                w_cnt_nxt = '0;
                if (rq0_valid_i && rq1_valid_i) begin
                    w_state_nxt = r_last ? ST_GNT0 : ST_GNT1;
                end else if (rq0_valid_i) begin
                    w_state_nxt = ST_GNT0;
                end else if (rq1_valid_i) begin
                    w_state_nxt = ST_GNT1;
                end
            end
            ST_GNT0, ST_GNT1: begin
                grant_o     = w_own ? 2'b10 : 2'b01;
                txu_byte_o  = w_byte;
                txu_en_o    = w_valid;
                rq0_ready_o = !w_own && txu_ready_i;
                rq1_ready_o = w_own && txu_ready_i;

                if (w_xfer) begin
                    w_cnt_nxt = '0;
                    if (!w_lock) begin
                        w_state_nxt = ST_IDLE;
                        w_last_nxt  = w_own;
                    end
                end else if (!w_valid) begin
                    if (!w_lock) begin
                        w_state_nxt = ST_IDLE;
                    end else if (uart_cken_i && (r_cnt != c_lock_tmo)) begin
                        w_cnt_nxt = w_cnt_inc;
                        if (w_cnt_inc == c_lock_tmo) begin
                            w_state_nxt = ST_IDLE;
                            w_last_nxt  = w_own;
                            w_tmo_nxt   = 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
